// File: rtl/boa_mem_arbiter_wrr_if.sv
// Boa memory bus bundle: flattened CPU-side ports plus the single memory port.
// Port i occupies slice i of every packed cpu_* vector.
interface boa_mem_arbiter_wrr_if #(
  parameter int alen = 32,
  parameter int dlen = 32,
  parameter int cpus = 2
);
  localparam int wes = dlen / 8;

  logic [cpus-1:0]          cpu_re;
  logic [cpus*wes-1:0]      cpu_we;
  logic [cpus*(alen-2)-1:0] cpu_addr;
  logic [cpus*dlen-1:0]     cpu_wdata;
  logic [cpus-1:0]          cpu_ready;
  logic [dlen-1:0]          cpu_rdata;

  logic                     mem_re;
  logic [wes-1:0]           mem_we;
  logic [alen-3:0]          mem_addr;
  logic [dlen-1:0]          mem_wdata;
  logic                     mem_ready;
  logic [dlen-1:0]          mem_rdata;

  // Arbiter view: accepts CPU requests, drives the memory port.
  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
    output cpu_ready, cpu_rdata, mem_re, mem_we, mem_addr, mem_wdata
  );

  // Environment view: CPU masters and memory model together.
  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
    input  cpu_ready, cpu_rdata, mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/boa_mem_arbiter_wrr.sv
// N-to-1 Boa memory bus arbiter with weighted round-robin (per-port burst
// quota) or static priority, stall-locked grants and registered completion
// routing. Memory completes a request one cycle after it is presented.
module boa_mem_arbiter_wrr #(
  parameter int alen  = 32,
  parameter int dlen  = 32,
  parameter int cpus  = 2,
  parameter int quota = 4,
  parameter int mode  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  boa_mem_arbiter_wrr_if.slave    bus,
  output logic [cpus-1:0]         grant
);
  localparam int wes = dlen / 8;
  localparam int aw  = alen - 2;
  localparam int cw  = $clog2(quota) + 1;
  localparam logic [cpus-1:0] one = cpus'(1);

  logic [cpus-1:0] req;
  logic [cpus-1:0] cur;
  logic [cpus-1:0] r_grant;
  logic [cpus-1:0] sel;
  logic [cpus-1:0] above;
  logic [cw-1:0]   cnt;
  logic [cw-1:0]   cnt_nx;
  logic            pend;
  logic            stall;

  // A port requests when it reads or asserts any write-enable lane.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req = '0;
    for (int i = 0; i < cpus; i++) begin
      req[i] = bus.cpu_re[i] | (|bus.cpu_we[i*wes +: wes]);
    end
  end

  assign stall = pend & ~bus.mem_ready;

  // Requesters strictly above the last owner; the last owner itself scans last.
  assign above = req & ~(cur | (cur - one));

  // Grant selection: stall lock, idle, quota continuation, or cyclic rescan.
  always_comb begin
    sel    = '0;
    cnt_nx = cnt;
    if (stall) begin
      sel = r_grant;
    end else if (req != '0) begin
      if (mode == 1) begin
        sel = req & (~req + one);
      end else if ((req & cur) != '0 && cnt < cw'(quota)) begin
        sel    = cur;
        cnt_nx = cnt + cw'(1);
      end else begin
        // Lowest requester above cur, else wrap to the lowest requester overall.
        if (above != '0) sel = above & (~above + one);
        else             sel = req & (~req + one);
        cnt_nx = cw'(1);
      end
    end
  end

  // NOTE: reset also gates the combinational grant so the memory port and
  // owner view go quiet the moment rst falls, not at the next edge.
  assign grant = rst ? sel : '0;

  // Owner, quota counter and in-flight tracking.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur     <= one;
      cnt     <= '0;
      pend    <= 1'b0;
      r_grant <= '0;
    end else begin
      if (grant != '0) cur <= grant;
      cnt     <= cnt_nx;
      pend    <= |grant;
      r_grant <= grant;
    end
  end

  // AND-OR mux of the granted port onto the memory bus; zero when idle.
  always_comb begin
    bus.mem_re    = 1'b0;
    bus.mem_we    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    for (int i = 0; i < cpus; i++) begin
      if (grant[i]) begin
        bus.mem_re    = bus.mem_re | bus.cpu_re[i];
        bus.mem_we    = bus.mem_we | bus.cpu_we[i*wes +: wes];
        bus.mem_addr  = bus.mem_addr | bus.cpu_addr[i*aw +: aw];
        bus.mem_wdata = bus.mem_wdata | bus.cpu_wdata[i*dlen +: dlen];
      end
    end
  end

  // Completion goes only to last cycle's owner, and only when memory answers.
  assign bus.cpu_ready = r_grant & {cpus{pend & bus.mem_ready}};
  assign bus.cpu_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_boa_mem_arbiter_wrr.sv
// Directed bench for boa_mem_arbiter_wrr: WRR sequence, single-port streaming,
// memory stall, write forwarding, asynchronous reset and static priority.
module tb_boa_mem_arbiter_wrr;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] g0;
  logic [2:0] g1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  boa_mem_arbiter_wrr_if #(.alen(32), .dlen(32), .cpus(3)) b0 ();
  boa_mem_arbiter_wrr_if #(.alen(32), .dlen(32), .cpus(3)) b1 ();

  boa_mem_arbiter_wrr #(.alen(32), .dlen(32), .cpus(3), .quota(2), .mode(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0), .grant(g0)
  );
  boa_mem_arbiter_wrr #(.alen(32), .dlen(32), .cpus(3), .quota(2), .mode(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .grant(g1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic port0(input int p, input logic re, input logic [3:0] we,
                       input logic [29:0] addr, input logic [31:0] wd);
    b0.cpu_re[p]          = re;
    b0.cpu_we[p*4 +: 4]   = we;
    b0.cpu_addr[p*30 +: 30] = addr;
    b0.cpu_wdata[p*32 +: 32] = wd;
  endtask

  task automatic port1(input int p, input logic re, input logic [29:0] addr);
    b1.cpu_re[p]            = re;
    b1.cpu_addr[p*30 +: 30] = addr;
  endtask

  logic [2:0]  eg [8];
  logic [2:0]  er [8];
  logic [29:0] ea [8];

  initial begin
    b0.cpu_re = '0; b0.cpu_we = '0; b0.cpu_addr = '0; b0.cpu_wdata = '0;
    b0.mem_ready = 1'b0; b0.mem_rdata = '0;
    b1.cpu_re = '0; b1.cpu_we = '0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.mem_ready = 1'b0; b1.mem_rdata = '0;

    // Reset held with all ports requesting: nothing may reach memory.
    for (int p = 0; p < 3; p++) port0(p, 1'b1, 4'h0, 30'h100 + 30'(p), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_grant", 64'(g0), 64'h0);
    check("rst_mem_re", 64'(b0.mem_re), 64'h0);
    check("rst_ready", 64'(b0.cpu_ready), 64'h0);

    // WRR, quota 2, three continuous requesters, memory always ready.
    eg = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
    er = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    ea = '{30'h100, 30'h100, 30'h101, 30'h101, 30'h102, 30'h102, 30'h100, 30'h100};
    rst = 1'b1;
    b0.mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("wrr_grant_%0d", i), 64'(g0), 64'(eg[i]));
      check($sformatf("wrr_ready_%0d", i), 64'(b0.cpu_ready), 64'(er[i]));
      check($sformatf("wrr_addr_%0d", i), 64'(b0.mem_addr), 64'(ea[i]));
    end

    // Only port 1 requests: five back-to-back transactions, no bubble.
    @(negedge clk);
    port0(0, 1'b0, 4'h0, 30'h100, 32'h0);
    port0(2, 1'b0, 4'h0, 30'h102, 32'h0);
    #1;
    check("solo_grant_0", 64'(g0), 64'h2);
    check("solo_ready_0", 64'(b0.cpu_ready), 64'h1);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); #1;
      check($sformatf("solo_grant_%0d", i), 64'(g0), 64'h2);
      check($sformatf("solo_ready_%0d", i), 64'(b0.cpu_ready), 64'h2);
    end
    @(negedge clk);
    port0(1, 1'b0, 4'h0, 30'h101, 32'h0);
    #1;
    check("solo_ready_last", 64'(b0.cpu_ready), 64'h2);
    check("solo_idle_grant", 64'(g0), 64'h0);
    check("solo_idle_re", 64'(b0.mem_re), 64'h0);

    // Stall: port 0 owns the bus, memory withholds ready for three cycles.
    @(negedge clk);
    port0(0, 1'b1, 4'h0, 30'h100, 32'h0);
    #1;
    check("stall_first_grant", 64'(g0), 64'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      port0(2, 1'b1, 4'h0, 30'h102, 32'h0);
      b0.mem_ready = 1'b0;
      #1;
      check($sformatf("stall_grant_%0d", i), 64'(g0), 64'h1);
      check($sformatf("stall_addr_%0d", i), 64'(b0.mem_addr), 64'h100);
      check($sformatf("stall_ready_%0d", i), 64'(b0.cpu_ready), 64'h0);
    end
    @(negedge clk);
    b0.mem_ready = 1'b1;
    #1;
    check("stall_done_ready", 64'(b0.cpu_ready), 64'h1);
    check("stall_quota_grant", 64'(g0), 64'h1);
    @(negedge clk);
    port0(0, 1'b0, 4'h0, 30'h100, 32'h0);
    #1;
    check("stall_p0_ready2", 64'(b0.cpu_ready), 64'h1);
    check("stall_p2_turn", 64'(g0), 64'h4);
    check("stall_p2_addr", 64'(b0.mem_addr), 64'h102);
    @(negedge clk); #1;
    check("stall_p2_ready", 64'(b0.cpu_ready), 64'h4);
    check("stall_p2_again", 64'(g0), 64'h4);
    @(negedge clk);
    port0(2, 1'b0, 4'h0, 30'h102, 32'h0);
    #1;
    check("stall_p2_ready2", 64'(b0.cpu_ready), 64'h4);
    check("stall_idle", 64'(g0), 64'h0);

    // Write from port 2 forwarded field-for-field; rdata broadcast.
    @(negedge clk);
    port0(2, 1'b0, 4'b0011, 30'h40, 32'hA5A5_1234);
    b0.mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("wr_grant", 64'(g0), 64'h4);
    check("wr_we", 64'(b0.mem_we), 64'h3);
    check("wr_wdata", 64'(b0.mem_wdata), 64'hA5A5_1234);
    check("wr_addr", 64'(b0.mem_addr), 64'h40);
    check("wr_re", 64'(b0.mem_re), 64'h0);
    check("rdata_bcast", 64'(b0.cpu_rdata), 64'hDEAD_BEEF);
    @(negedge clk);
    port0(2, 1'b0, 4'h0, 30'h102, 32'h0);
    #1;
    check("wr_ready", 64'(b0.cpu_ready), 64'h4);
    check("wr_idle_we", 64'(b0.mem_we), 64'h0);

    // Asynchronous reset in flight, then RR restart from port 1.
    @(negedge clk);
    port0(2, 1'b1, 4'h0, 30'h102, 32'h0);
    #1;
    check("rst_pre_grant", 64'(g0), 64'h4);
    @(negedge clk); #1;
    check("rst_pre_ready", 64'(b0.cpu_ready), 64'h4);
    #1 rst = 1'b0;
    #1;
    check("rst_async_grant", 64'(g0), 64'h0);
    check("rst_async_re", 64'(b0.mem_re), 64'h0);
    check("rst_async_we", 64'(b0.mem_we), 64'h0);
    check("rst_async_ready", 64'(b0.cpu_ready), 64'h0);
    @(negedge clk);
    port0(1, 1'b1, 4'h0, 30'h101, 32'h0);
    #1;
    check("rst_hold_grant", 64'(g0), 64'h0);
    check("rst_hold_ready", 64'(b0.cpu_ready), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_grant_0", 64'(g0), 64'h2);
    check("rel_ready_0", 64'(b0.cpu_ready), 64'h0);
    @(negedge clk); #1;
    check("rel_grant_1", 64'(g0), 64'h2);
    check("rel_ready_1", 64'(b0.cpu_ready), 64'h2);
    @(negedge clk); #1;
    check("rel_grant_2", 64'(g0), 64'h4);
    check("rel_ready_2", 64'(b0.cpu_ready), 64'h2);
    @(negedge clk);
    b0.cpu_re = '0;

    // Static priority: port 1 starves port 2 until it drops.
    port1(1, 1'b1, 30'h201);
    port1(2, 1'b1, 30'h202);
    b1.mem_ready = 1'b1;
    #1;
    check("prio_grant_0", 64'(g1), 64'h2);
    check("prio_ready_0", 64'(b1.cpu_ready), 64'h0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #1;
      check($sformatf("prio_grant_%0d", i), 64'(g1), 64'h2);
      check($sformatf("prio_ready_%0d", i), 64'(b1.cpu_ready), 64'h2);
    end
    @(negedge clk);
    port1(1, 1'b0, 30'h201);
    #1;
    check("prio_p2_grant", 64'(g1), 64'h4);
    check("prio_p2_addr", 64'(b1.mem_addr), 64'h202);
    check("prio_p1_last_ready", 64'(b1.cpu_ready), 64'h2);
    @(negedge clk); #1;
    check("prio_p2_ready", 64'(b1.cpu_ready), 64'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
